// File: rtl/jitter_fifo_pkg.sv
// Shared types and constants for the jitter FIFO: delay modes, read FSM states,
// LFSR taps/seed and the per-read delay calculation.
package jitter_fifo_pkg;

  typedef enum logic [1:0] {
    ModeBypass          = 2'd0,
    ModeFixed           = 2'd1,
    ModeRandom          = 2'd2,
    ModeFixedPlusRandom = 2'd3
  } mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } rd_state_e;

  // x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0 feed the XOR.
  localparam logic [31:0] LfsrTaps        = 32'h8020_0003;
  localparam logic [31:0] LfsrDefaultSeed = 32'h3ADE_68B1;

  // Only the low LFSR byte contributes; the full word is passed for convenience.
  function automatic logic [7:0] calc_delay(input mode_e       mode,
                                            input logic [7:0]  fixed_delay,
                                            input logic [7:0]  delay_mask,
                                            input logic [31:0] lfsr);
    logic [7:0] rnd;
    logic [8:0] sum;
    rnd = lfsr[7:0] & delay_mask;
    sum = {1'b0, fixed_delay} + {1'b0, rnd};
    case (mode)
      ModeBypass:  calc_delay = 8'd0;
      ModeFixed:   calc_delay = fixed_delay;
      ModeRandom:  calc_delay = rnd;
      default:     calc_delay = sum[8] ? 8'hFF : sum[7:0];
    endcase
  endfunction

endpackage

// File: rtl/jitter_lfsr.sv
// 32-bit Fibonacci LFSR that steps only when advance_i is high.
module jitter_lfsr
  import jitter_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        advance_i,
  input  logic [31:0] seed_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (advance_i) begin
      state_d = {state_q[30:0], ^(state_q & LfsrTaps)};
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q <= seed_i;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jitter_fifo.sv
// FIFO whose reads are released after a bypass, fixed, random or combined delay,
// the random part drawn from an LFSR that steps once per pop.
module jitter_fifo
  import jitter_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] LFSR_SEED = LfsrDefaultSeed
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] din_i,
  input  logic              wr_en_i,
  output logic              full_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  input  logic [1:0]        mode_i,
  input  logic [7:0]        fixed_delay_i,
  input  logic [7:0]        delay_mask_i
);

  localparam int unsigned   Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(Depth);
  localparam logic [31:0]   SeedEff = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  rd_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, delay;
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;
  logic              wr, pop;
  logic [31:0]       lfsr_state;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == FullCnt);
  assign count_o      = count_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign wr           = wr_en_i && !full_o;

  jitter_lfsr u_lfsr (
    .clk      (clk),
    .srst     (srst),
    .advance_i(pop),
    .seed_i   (SeedEff),
    .state_o  (lfsr_state)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    delay   = calc_delay(mode_e'(mode_i), fixed_delay_i, delay_mask_i, lfsr_state);
    unique case (state_q)
      StIdle: begin
        if (rd_en_i && !empty_o) begin
          if (delay == 8'd0) begin
            pop = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = delay;
          end
        end
      end
      StWait: begin
        // Counter freezes while rd_en_i is low; pop on the last remaining edge.
        if (rd_en_i) begin
          if (cnt_q == 8'd1) begin
            pop     = 1'b1;
            state_d = StIdle;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (wr && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= pop;
      dout_q  <= pop ? mem_q[rd_ptr_q] : '0;
      if (wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: tb/tb_jitter_fifo.sv
// Directed and randomized checks of jitter_fifo against a queue-based model with
// a reference LFSR stepped once per expected pop.
module tb_jitter_fifo;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] SEED  = 32'h3ADE_68B1;

  logic       clk = 1'b0;
  logic       srst = 1'b0;
  logic [7:0] din = 8'h0;
  logic       wr_en = 1'b0;
  logic       full;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       empty;
  logic [8:0] count;
  logic [1:0] mode = 2'd0;
  logic [7:0] fixed_delay = 8'd0;
  logic [7:0] delay_mask = 8'd0;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] lfsr_m;
  logic [7:0]  fifo_m[$];
  int          run1[100];

  jitter_fifo dut (
    .clk          (clk),
    .srst         (srst),
    .din_i        (din),
    .wr_en_i      (wr_en),
    .full_o       (full),
    .rd_en_i      (rd_en),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .empty_o      (empty),
    .count_o      (count),
    .mode_i       (mode),
    .fixed_delay_i(fixed_delay),
    .delay_mask_i (delay_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic int exp_delay(input int m, input int fx, input int mk, input logic [31:0] s);
    int r;
    r = int'(s[7:0]) & mk;
    case (m)
      0: return 0;
      1: return fx;
      2: return r;
      default: return (fx + r > 255) ? 255 : fx + r;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    srst = 1'b1;
    #3;
    srst = 1'b0;
    lfsr_m = SEED;
    fifo_m.delete();
  endtask

  task automatic push(input logic [7:0] d);
    din = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    fifo_m.push_back(d);
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    while (!dout_valid && e < 300) begin
      tick();
      e++;
    end
    check("valid_seen", dout_valid, 1);
  endtask

  // Accepts one read, returns edges from acceptance to pop, and checks the data.
  task automatic read_one(output int d);
    logic [7:0] exp;
    rd_en = 1'b1;
    tick();
    wait_valid(d);
    rd_en = 1'b0;
    exp = (fifo_m.size() > 0) ? fifo_m.pop_front() : 8'h00;
    check("read_data", dout, exp);
    lfsr_m = lfsr_step(lfsr_m);
  endtask

  initial begin
    int d, e, expd;
    logic we, re, exp_pop, exp_wr;
    logic [7:0] expb, wd;

    do_reset();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);

    // Bypass: three back-to-back pops.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    mode = 2'd0;
    rd_en = 1'b1;
    tick();
    check("byp_v0", dout_valid, 1);
    check("byp_d0", dout, 8'h11);
    tick();
    check("byp_v1", dout_valid, 1);
    check("byp_d1", dout, 8'h22);
    tick();
    check("byp_v2", dout_valid, 1);
    check("byp_d2", dout, 8'h33);
    rd_en = 1'b0;
    tick();
    check("byp_v_off", dout_valid, 0);
    check("byp_dout_zero", dout, 0);
    check("byp_empty", empty, 1);
    check("byp_count", count, 0);
    repeat (3) begin
      void'(fifo_m.pop_front());
      lfsr_m = lfsr_step(lfsr_m);
    end

    // Fixed delay of 3.
    mode = 2'd1;
    fixed_delay = 8'd3;
    push(8'hA5);
    read_one(d);
    check("fixed3_delay", d, 3);

    // Fixed delay of 4 with rd_en dropped for two edges; settings changed mid-wait.
    fixed_delay = 8'd4;
    push(8'h5A);
    rd_en = 1'b1;
    tick();
    mode = 2'd0;
    fixed_delay = 8'd0;
    tick();
    rd_en = 1'b0;
    tick();
    tick();
    check("hold_no_valid", dout_valid, 0);
    rd_en = 1'b1;
    tick();
    wait_valid(e);
    rd_en = 1'b0;
    check("hold_delay", 4 + e, 6);
    check("hold_data", dout, fifo_m.pop_front());
    lfsr_m = lfsr_step(lfsr_m);

    // Fill, overflow, simultaneous write+pop while full, then random traffic.
    mode = 2'd0;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    check("fill_full", full, 1);
    check("fill_count", count, DEPTH);
    din = 8'hEE;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    check("drop_count", count, DEPTH);
    check("drop_full", full, 1);
    din = 8'hDD;
    wr_en = 1'b1;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("wp_full_valid", dout_valid, 1);
    check("wp_full_data", dout, fifo_m.pop_front());
    lfsr_m = lfsr_step(lfsr_m);
    check("wp_full_count", count, DEPTH - 1);
    check("wp_full_flag", full, 0);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      exp_pop = re && (fifo_m.size() > 0);
      exp_wr = we && (fifo_m.size() < DEPTH);
      din = wd;
      wr_en = we;
      rd_en = re;
      tick();
      expb = 8'h00;
      if (exp_pop) begin
        expb = fifo_m.pop_front();
        lfsr_m = lfsr_step(lfsr_m);
      end
      if (exp_wr) fifo_m.push_back(wd);
      check("trf_valid", dout_valid, exp_pop);
      check("trf_data", dout, expb);
      check("trf_count", count, fifo_m.size());
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    while (fifo_m.size() > 0) begin
      tick();
      check("drain_valid", dout_valid, 1);
      check("drain_data", dout, fifo_m.pop_front());
      lfsr_m = lfsr_step(lfsr_m);
    end
    rd_en = 1'b0;
    tick();
    check("drain_empty", empty, 1);

    // Random delays, masked to 0..7, reproducible after reset.
    for (int run = 0; run < 2; run++) begin
      do_reset();
      mode = 2'd2;
      delay_mask = 8'h07;
      for (int i = 0; i < 100; i++) push(8'($urandom));
      for (int i = 0; i < 100; i++) begin
        expd = exp_delay(2, 0, 7, lfsr_m);
        read_one(d);
        check("rnd_range", d <= 7, 1);
        check("rnd_delay", d, expd);
        if (run == 0) run1[i] = d;
        else check("rnd_repeat", d, run1[i]);
      end
    end

    // Fixed plus random, saturating at 255.
    mode = 2'd3;
    fixed_delay = 8'd250;
    delay_mask = 8'hFF;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    for (int i = 0; i < 3; i++) begin
      expd = exp_delay(3, 250, 255, lfsr_m);
      read_one(d);
      check("fpr_delay", d, expd);
    end

    // Reset in the middle of a wait abandons the read and reseeds the LFSR.
    mode = 2'd1;
    fixed_delay = 8'd10;
    push(8'h77);
    rd_en = 1'b1;
    tick();
    tick();
    tick();
    check("midwait_valid", dout_valid, 0);
    #2;
    srst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_valid", dout_valid, 0);
    srst = 1'b0;
    lfsr_m = SEED;
    fifo_m.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("arst_no_valid", dout_valid, 0);
    end
    rd_en = 1'b0;
    mode = 2'd2;
    delay_mask = 8'hFF;
    push(8'h99);
    expd = exp_delay(2, 0, 255, lfsr_m);
    read_one(d);
    check("reseed_delay", d, expd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
